fifo_push_arbiter: RTL

//  Round-robin, burst-locked arbiter sharing the push port of one asymmetric_fifo among NUM_REQ

---
 rtl/fifo_push_arbiter_if.sv | 29 ++
 rtl/fifo_push_arbiter.sv | 139 +++++++++++++
 2 files changed

// File: rtl/fifo_push_arbiter_if.sv
// Push-side bundle between NUM_REQ wide-word producers, the arbiter and one FIFO write port.
// master: producer/FIFO environment side; slave: the arbiter.
interface fifo_push_arbiter_if #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned WIDTH_IN = 64
);
  localparam int unsigned ReqBits = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]          req;
  logic [NUM_REQ-1:0]          req_last;
  logic [NUM_REQ*WIDTH_IN-1:0] req_d;
  logic [NUM_REQ-1:0]          ack;
  logic                        fifo_push;
  logic [WIDTH_IN-1:0]         fifo_d;
  logic                        fifo_full;
  logic                        fifo_almost_full;
  logic [ReqBits-1:0]          owner;
  logic                        busy;

  modport master (
    output req, req_last, req_d, fifo_full, fifo_almost_full,
    input  ack, fifo_push, fifo_d, owner, busy
  );

  modport slave (
    input  req, req_last, req_d, fifo_full, fifo_almost_full,
    output ack, fifo_push, fifo_d, owner, busy
  );
endinterface

// File: rtl/fifo_push_arbiter.sv
// Round-robin, burst-locked arbiter in front of a FIFO write port.
// One owner holds the port for up to BURST_MAX beats or until its packet ends or it withdraws;
// hand-off to the next pending requester happens without a bubble cycle. The FIFO write is
// registered and throttled so at most one push is ever in flight against almost_full.
module fifo_push_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned WIDTH_IN  = 64,
  parameter int unsigned BURST_MAX = 4
) (
  input logic                clk,
  input logic                rst_n,
  fifo_push_arbiter_if.slave arb_io
);
  localparam int unsigned ReqBits = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CntW    = $clog2(BURST_MAX) + 1;

  localparam logic [CntW-1:0]    BurstMaxC = CntW'(BURST_MAX);
  localparam logic [ReqBits-1:0] LastIdx   = ReqBits'(NUM_REQ - 1);

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  state_e              state_q;
  logic [ReqBits-1:0]  owner_q;
  logic [ReqBits-1:0]  rr_ptr_q;
  logic [CntW-1:0]     beat_cnt_q;
  logic                fifo_push_q;
  logic [WIDTH_IN-1:0] fifo_d_q;

  // Explicit wrap so non power-of-two NUM_REQ never indexes past the last requester.
  function automatic logic [ReqBits-1:0] wrap_inc(input logic [ReqBits-1:0] idx);
    return (idx == LastIdx) ? '0 : idx + ReqBits'(1);
  endfunction

  // First asserted request scanning start, start+1, ... (mod NUM_REQ).
  function automatic logic [ReqBits-1:0] rr_pick(input logic [ReqBits-1:0] start,
                                                 input logic [NUM_REQ-1:0] req);
    logic [ReqBits-1:0] idx;
    logic [ReqBits-1:0] res;
    logic               found;
    idx   = start;
    res   = start;
    found = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!found && req[idx]) begin
        res   = idx;
        found = 1'b1;
      end
      idx = wrap_inc(idx);
    end
    return res;
  endfunction

  logic                can_push;
  logic                own_req;
  logic                own_last;
  logic [WIDTH_IN-1:0] own_data;
  logic                accept;
  logic [CntW-1:0]     cnt_inc;
  logic                burst_end;
  logic [ReqBits-1:0]  rr_next;
  logic [NUM_REQ-1:0]  others;
  logic                pending;
  logic [ReqBits-1:0]  idle_pick;
  logic [ReqBits-1:0]  hand_pick;
  logic [NUM_REQ-1:0]  ack;

  // Beat acceptance, burst termination and next-owner selection.
  always_comb begin
    // A push already in flight may be the one that fills the FIFO, so almost_full blocks it.
    can_push  = !arb_io.fifo_full && !(arb_io.fifo_almost_full && fifo_push_q);
    own_req   = arb_io.req[owner_q];
    own_last  = arb_io.req_last[owner_q];
    own_data  = arb_io.req_d[owner_q*WIDTH_IN +: WIDTH_IN];
    accept    = (state_q == StBurst) && own_req && can_push;
    cnt_inc   = beat_cnt_q + CntW'(1);
    burst_end = (state_q == StBurst) &&
                (!own_req || (accept && (own_last || (cnt_inc == BurstMaxC))));
    rr_next   = wrap_inc(owner_q);
    others    = arb_io.req;
    others[owner_q] = 1'b0;
    // Old owner stays eligible only if its packet continues past this beat.
    pending   = (|others) || (own_req && !own_last);
    idle_pick = rr_pick(rr_ptr_q, arb_io.req);
    hand_pick = rr_pick(rr_next, arb_io.req);
    ack       = '0;
    if (accept) begin
      ack[owner_q] = 1'b1;
    end
  end

  // Arbiter state, owner bookkeeping and the registered FIFO write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      beat_cnt_q  <= '0;
      fifo_push_q <= 1'b0;
      fifo_d_q    <= '0;
    end else begin
      fifo_push_q <= accept;
      if (accept) begin
        fifo_d_q   <= own_data;
        beat_cnt_q <= cnt_inc;
      end
      case (state_q)
        StIdle: begin
          if (|arb_io.req) begin
            owner_q    <= idle_pick;
            beat_cnt_q <= '0;
            state_q    <= StBurst;
          end
        end
        StBurst: begin
          if (burst_end) begin
            rr_ptr_q <= rr_next;
            if (pending) begin
              owner_q    <= hand_pick;
              beat_cnt_q <= '0;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign arb_io.ack       = ack;
  assign arb_io.fifo_push = fifo_push_q;
  assign arb_io.fifo_d    = fifo_d_q;
  assign arb_io.owner     = owner_q;
  assign arb_io.busy      = (state_q == StBurst);

  // Throttling must never let a push land on a full FIFO.
  no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
                                      !(fifo_push_q && arb_io.fifo_full));
endmodule
